regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file with a per-register busy scoreboard, replacing the fixed two-read, one-write 32x32 register file in the pipeline decode stage. It provides NUM_RD registered read ports, one write port from writeback, and an optional same-cycle write-to-read bypass. It also tracks outstanding destination writes so that decode can detect RAW hazards without separate logic.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and busy-set
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe from writeback
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  registered busy flag of the register addressed by each port
- set_en  in  1  issue strobe: marks set_addr as having a write pending
- set_addr  in  ADDR_W  destination register of the issued instruction

## Operation
- **Storage:** 2**ADDR_W words of DATA_W bits, plus one busy bit per word.
- **Write:** on a rising edge with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - When ZERO_REG=1 and wr_addr=0, the write is dropped.
- **Busy set:** on a rising edge with set_en=1, busy[set_addr] <= 1.
  - When ZERO_REG=1 and set_addr=0, the set is dropped.
- **Set and clear on the same address in the same cycle:** set wins, so the busy bit stays 1 (the new producer supersedes the retiring one).
- **Read:** every rising edge, each port i registers rd_data[i] and rd_busy[i] from rd_addr[i]. There is no read enable; ports are always active.
- **Zero register:** with ZERO_REG=1, a read of address 0 gives data 0 and busy 0, regardless of bypass.
- **Read ports are independent:** any number of ports may address the same register.
- **Reset:** while rst_n=0, all memory words, all busy bits, rd_data and rd_busy are 0.

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on rd_data/rd_busy after edge N and holds until edge N+1.
- Write latency is 1 cycle. Whether a read sampled at the same edge sees the new value is set by the bypass option (see Configuration).
- Reset is asynchronous: the falling edge of rst_n clears all state and outputs immediately, without a clock edge.
  - Deassertion is synchronised externally.
  - Writes and sets in the edge coincident with deassertion are not guaranteed.
- A reset that interrupts an in-flight write loses that write; all busy bits return to 0.
- There are no stalls or back-pressure; the block accepts one write and one set every cycle.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- **Defined:** a read port whose rd_addr equals wr_addr while wr_en=1 (and the address is not zero-register) returns wr_data at that edge. Its rd_busy reflects the post-edge busy state: 0 if cleared, 1 if set_en targets the same address.
- **Undefined:** reads return the pre-edge memory and busy contents (read-before-write). Writeback forwarding must then be handled by the pipeline.

## Structure
- Shared package regfile_pkg holds:
  - default constants REGFILE_DATA_W=32 and REGFILE_ADDR_W=5
  - typedefs reg_addr_t and reg_data_t
- Sub-module regfile_scoreboard contains the busy-bit array, the set/clear priority logic, and per-port busy lookup. It takes the same parameters and the same bypass macro.
- The data array and read-port generate loop stay in regfile_mp.

## Test plan
- **Reset:** drive rst_n=0 mid-cycle after arbitrary writes -> rd_data=0 and rd_busy=0 on all ports immediately; all registers then read 0.
- **Write then read:** write r5=0x0000000A; next cycle rd_addr port0=5, port1=5 -> both ports return 0x0000000A one edge later.
- **Zero register:** write r0=0xFFFFFFFF with set_en at set_addr=0 -> reading r0 returns data 0 and busy 0.
- **Same-cycle write and read of r3:**
  - Setup: r3=0x11111111; in one cycle write r3=0x00001234 and read r3.
  - With REGFILE_BYPASS_EN: the read returns 0x00001234.
  - Without it: the read returns 0x11111111, and the next read returns 0x00001234.
- **Scoreboard:**
  - set_en on r7 -> a read of r7 gives rd_busy=1.
  - A write to r7 clears it -> rd_busy=0.
  - Simultaneous set_en r7 and write r7 -> rd_busy stays 1 and data is updated.
- **Port independence with NUM_RD=4:** read r1, r2, r3, r4 holding 1, 2, 3, 4 -> each port returns its own value in the same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the decode-stage register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, registered per-port lookup.
// Optional macro REGFILE_BYPASS_EN: a port reading the register being written sees post-edge busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             clr_ok;
  logic             set_ok;

  assign clr_ok = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

  // Set is applied last so a new producer overrides the retiring one on the same register.
  always_comb begin
    busy_nxt = busy;
    if (clr_ok) busy_nxt[wr_addr]  = 1'b0;
    if (set_ok) busy_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              b_nxt;
    logic              b_q;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      b_nxt = busy[addr];
`ifdef REGFILE_BYPASS_EN
      if (clr_ok && (wr_addr == addr)) b_nxt = busy_nxt[addr];
`endif
      if ((ZERO_REG != 0) && (addr == '0)) b_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) b_q <= 1'b0;
      else        b_q <= b_nxt;
    end

    assign rd_busy[i] = b_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-edge write data is forwarded to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Storage is flop-based so the whole array clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mem <= '{default: '0};
    else if (wr_ok) mem[wr_addr] <= wr_data;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_nxt;
    logic [DATA_W-1:0] d_q;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      d_nxt = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == addr)) d_nxt = wr_data;
`endif
      if ((ZERO_REG != 0) && (addr == '0)) d_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= '0;
      else        d_q <= d_nxt;
    end

    assign rd_data[i*DATA_W +: DATA_W] = d_q;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .set_en   (set_en),
    .set_addr (set_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (4 read ports); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NRD = 4;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          wr_en;
  reg_addr_t                     wr_addr;
  reg_data_t                     wr_data;
  logic [NRD*REGFILE_ADDR_W-1:0] rd_addr;
  logic [NRD*REGFILE_DATA_W-1:0] rd_data;
  logic [NRD-1:0]                rd_busy;
  logic                          set_en;
  reg_addr_t                     set_addr;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp #(
    .DATA_W   (REGFILE_DATA_W),
    .ADDR_W   (REGFILE_ADDR_W),
    .NUM_RD   (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .set_en   (set_en),
    .set_addr (set_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic reg_data_t port_data(input int p);
    return rd_data[p*REGFILE_DATA_W +: REGFILE_DATA_W];
  endfunction

  task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2, input reg_addr_t a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    set_en = 1'b0;
  endtask

  task automatic do_write(input reg_addr_t a, input reg_data_t d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    idle();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    set_en = 1'b0; set_addr = '0;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    #3;
    check("reset_data", rd_data[31:0], 32'h0);
    check("reset_busy", {28'h0, rd_busy}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // write then read on two ports
    do_write(5'd5, 32'h0000000A);
    set_rd(5'd5, 5'd5, 5'd0, 5'd0);
    step();
    check("wr_rd_p0", port_data(0), 32'h0000000A);
    check("wr_rd_p1", port_data(1), 32'h0000000A);
    check("wr_rd_busy", {28'h0, rd_busy}, 32'h0);

    // zero register ignores write and busy-set, even read in the same cycle
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    set_en = 1'b1; set_addr = 5'd0;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    step();
    idle();
    check("zero_same_data", port_data(0), 32'h0);
    step();
    check("zero_data", port_data(0), 32'h0);
    check("zero_busy", {28'h0, rd_busy}, 32'h0);

    // same-cycle write and read of r3
    do_write(5'd3, 32'h11111111);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00001234;
    set_rd(5'd3, 5'd0, 5'd0, 5'd0);
    step();
    idle();
`ifdef REGFILE_BYPASS_EN
    check("r3_same", port_data(0), 32'h00001234);
`else
    check("r3_same", port_data(0), 32'h11111111);
`endif
    step();
    check("r3_next", port_data(0), 32'h00001234);

    // scoreboard: set, clear, simultaneous set+clear
    set_rd(5'd7, 5'd0, 5'd0, 5'd0);
    set_en = 1'b1; set_addr = 5'd7;
    step();
    idle();
    check("sb_set_same", {31'h0, rd_busy[0]}, 32'h0);
    step();
    check("sb_set", {31'h0, rd_busy[0]}, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    step();
    idle();
`ifdef REGFILE_BYPASS_EN
    check("sb_clr_same", {31'h0, rd_busy[0]}, 32'h0);
    check("sb_clr_same_d", port_data(0), 32'h77);
`else
    check("sb_clr_same", {31'h0, rd_busy[0]}, 32'h1);
    check("sb_clr_same_d", port_data(0), 32'h0);
`endif
    step();
    check("sb_clr", {31'h0, rd_busy[0]}, 32'h0);
    check("sb_clr_d", port_data(0), 32'h77);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h99;
    set_en = 1'b1; set_addr = 5'd7;
    step();
    idle();
`ifdef REGFILE_BYPASS_EN
    check("sb_both_same", {31'h0, rd_busy[0]}, 32'h1);
`else
    check("sb_both_same", {31'h0, rd_busy[0]}, 32'h0);
`endif
    step();
    check("sb_both_busy", {31'h0, rd_busy[0]}, 32'h1);
    check("sb_both_d", port_data(0), 32'h99);

    // four ports read independent registers, one of them busy
    do_write(5'd1, 32'h1);
    do_write(5'd2, 32'h2);
    do_write(5'd3, 32'h3);
    do_write(5'd4, 32'h4);
    set_en = 1'b1; set_addr = 5'd2;
    step();
    idle();
    set_rd(5'd1, 5'd2, 5'd3, 5'd4);
    step();
    for (int p = 0; p < NRD; p++)
      check($sformatf("port%0d", p), port_data(p), p + 1);
    check("port_busy", {28'h0, rd_busy}, 32'h2);

    // asynchronous reset mid-cycle clears outputs at once, then all state
    do_write(5'd9, 32'hDEADBEEF);
    set_en = 1'b1; set_addr = 5'd10;
    step();
    idle();
    set_rd(5'd9, 5'd10, 5'd5, 5'd7);
    step();
    check("pre_rst_d", port_data(0), 32'hDEADBEEF);
    check("pre_rst_b", {28'h0, rd_busy}, 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_d", port_data(0), 32'h0);
    check("rst_async_b", {28'h0, rd_busy}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int p = 0; p < NRD; p++)
      check($sformatf("post_rst_p%0d", p), port_data(p), 32'h0);
    check("post_rst_busy", {28'h0, rd_busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
